mem_dma_master: RTL and testbench

- Initiator-side engine for the single-port data memory interface (MemRead/MemWrite/Address/WriteData/ReadData).
- Performs a block copy (src→dst) or a block fill (constant→dst) of up to 2^LEN_WIDTH-1 words without CPU involvement.
- Sits between the control path and the data memory; when busy it owns the memory port.

---
 rtl/mem_dma_master.sv | 135 +++++++++++++
 tb/tb_mem_dma_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dma_master.sv
// Block copy / block fill engine for the single-port data memory.
// Owns the memory port whenever it is busy.
module mem_dma_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WriteData,
  input  logic [DATA_WIDTH-1:0] ReadData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic                  op_q, op_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      fill_q  <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      op_q    <= op_d;
    end
  end

  assign words_done = words_q;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    words_d   = words_q;
    data_d    = data_q;
    fill_d    = fill_q;
    op_d      = op_q;
    busy      = 1'b0;
    done      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = length;
          fill_d  = fill_value;
          words_d = '0;
          if (length == '0)  state_d = S_DONE;
          else if (op)       state_d = S_WRITE;
          else               state_d = S_READ;
        end
      end
      S_READ: begin
        busy    = 1'b1;
        Address = src_q;
        // abort suppresses the strobe in the same cycle and drops all updates
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          MemRead = 1'b1;
          data_d  = ReadData;
          src_d   = src_q + ADDR_WIDTH'(1);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        busy      = 1'b1;
        Address   = dst_q;
        WriteData = op_q ? fill_q : data_q;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          MemWrite = 1'b1;
          dst_d    = dst_q + ADDR_WIDTH'(1);
          rem_d    = rem_q - LEN_WIDTH'(1);
          words_d  = words_q + LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DONE;
          else if (op_q)              state_d = S_WRITE;
          else                        state_d = S_READ;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_dma_master.sv
// Self-checking bench for mem_dma_master: directed table, reset corner case,
// and randomized transfers against a word-level memory reference model.
module tb_mem_dma_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [7:0] length = '0;
  logic [7:0] fill_value = '0;
  logic       busy, done, MemRead, MemWrite;
  logic [7:0] words_done, Address, WriteData, ReadData;

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       load_en = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign ReadData = mem[Address];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (MemWrite) begin
      mem[Address] <= WriteData;
    end
  end

  mem_dma_master #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .LEN_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .fill_value(fill_value),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .words_done(words_done),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Reference: word-by-word ascending transfer over a copy of memory, producing
  // the expected per-cycle bus view {busy,done,rd,wr,addr,wdata} plus a care mask.
  task automatic run_xfer(input string tag, input logic o, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] n, input logic [7:0] f, input int abort_at,
                          input bit spam, output int obs_done, output logic [7:0] obs_words);
    logic [7:0]  rm [256];
    logic [19:0] ev [$];
    logic [19:0] em [$];
    logic [19:0] obs;
    logic [7:0]  a, w, sa;
    int          k, wexp, bad;
    bit          ab;
    for (int i = 0; i < 256; i++) rm[i] = mem[i];
    k = 0; wexp = 0; ab = 1'b0;
    for (int i = 0; i < int'(n) && !ab; i++) begin
      sa = s + 8'(i);
      if (!o) begin
        if (k == abort_at) ab = 1'b1;
        else begin
          ev.push_back({4'b1010, sa, 8'h00});
          em.push_back(20'hFFF00);
          k++;
        end
      end
      if (!ab) begin
        if (k == abort_at) ab = 1'b1;
        else begin
          a = d + 8'(i);
          w = o ? f : rm[sa];
          rm[a] = w;
          ev.push_back({4'b1001, a, w});
          em.push_back('1);
          k++;
          wexp++;
        end
      end
    end
    if (ab) begin
      ev.push_back({4'b1000, 16'h0000});
      em.push_back(20'hF0000);
    end else begin
      ev.push_back({4'b1100, 16'h0000});
      em.push_back('1);
    end
    ev.push_back(20'h00000);
    em.push_back('1);

    @(negedge clk);
    op = o; src_addr = s; dst_addr = d; length = n; fill_value = f;
    start = 1'b1;
    abort = (abort_at == -2);
    obs_done = 0;
    for (int j = 0; j < ev.size(); j++) begin
      @(negedge clk);
      start = spam && (j == 1) && (j < ev.size() - 1);
      abort = (j == abort_at);
      op = 1'($urandom); src_addr = 8'($urandom); dst_addr = 8'($urandom);
      length = 8'($urandom); fill_value = 8'($urandom);
      #1;
      obs = {busy, done, MemRead, MemWrite, Address, WriteData};
      if (done === 1'b1 && obs_done == 0) obs_done = j + 1;
      chk($sformatf("%s bus cycle %0d", tag, j), {12'h000, obs & em[j]}, {12'h000, ev[j] & em[j]});
    end
    start = 1'b0;
    abort = 1'b0;
    obs_words = words_done;
    chk($sformatf("%s words_done vs model", tag), {24'h0, words_done}, 32'(wexp));
    bad = -1;
    for (int i = 0; i < 256; i++) if (bad < 0 && mem[i] !== rm[i]) bad = i;
    if (bad < 0) chk($sformatf("%s memory image", tag), 32'h0, 32'h0 | {24'h0, mem[0] ^ rm[0]});
    else chk($sformatf("%s memory word %0h", tag, bad), {24'h0, mem[bad]}, {24'h0, rm[bad]});
  endtask

  typedef struct {
    string      name;
    logic       op;
    logic [7:0] src, dst, len, fill;
    int         abort_at;
    bit         spam;
    int         exp_done;
    logic [7:0] exp_words;
  } vec_t;

  initial begin
    vec_t       vt [8];
    int         od;
    logic [7:0] ow, v0;

    vt[0] = '{"copy2",       1'b0, 8'h00, 8'h02, 8'd2, 8'h00, -1, 1'b0, 5, 8'd2};
    vt[1] = '{"fill4",       1'b1, 8'h00, 8'h00, 8'd4, 8'hA5, -1, 1'b1, 5, 8'd4};
    vt[2] = '{"len0",        1'b0, 8'h10, 8'h20, 8'd0, 8'h00, -1, 1'b0, 1, 8'd0};
    vt[3] = '{"fill_wrap",   1'b1, 8'h00, 8'hFF, 8'd2, 8'h5A, -1, 1'b0, 3, 8'd2};
    vt[4] = '{"copy_abort",  1'b0, 8'h00, 8'h04, 8'd4, 8'h00,  3, 1'b1, 0, 8'd1};
    vt[5] = '{"abort_done",  1'b1, 8'h00, 8'h10, 8'd2, 8'h3C,  2, 1'b0, 3, 8'd2};
    vt[6] = '{"copy_overlap",1'b0, 8'h00, 8'h01, 8'd3, 8'h00, -1, 1'b0, 7, 8'd3};
    vt[7] = '{"start_abort", 1'b1, 8'h00, 8'h30, 8'd1, 8'h77, -2, 1'b0, 2, 8'd1};

    #1;
    chk("reset outputs", {4'h0, busy, done, MemRead, MemWrite, Address, WriteData, words_done}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[0] = 8'd3;
    img[1] = 8'd2;
    load_mem();

    for (int i = 0; i < 8; i++) begin
      run_xfer(vt[i].name, vt[i].op, vt[i].src, vt[i].dst, vt[i].len, vt[i].fill,
               vt[i].abort_at, vt[i].spam, od, ow);
      chk({vt[i].name, " done cycle"}, 32'(od), 32'(vt[i].exp_done));
      chk({vt[i].name, " words"}, {24'h0, ow}, {24'h0, vt[i].exp_words});
    end

    // asynchronous reset during the second WRITE of a copy
    v0 = mem[0];
    @(negedge clk);
    op = 1'b0; src_addr = 8'h00; dst_addr = 8'h08; length = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk("rst_seq read", {31'h0, MemRead}, 32'h1);
    @(negedge clk);
    #1 chk("rst_seq write", {31'h0, MemWrite}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_seq words before reset", {24'h0, words_done}, 32'h1);
    rst = 1'b1;
    #1 chk("rst_seq outputs cleared", {4'h0, busy, done, MemRead, MemWrite, Address, WriteData, words_done}, 32'h0);
    chk("rst_seq kept write", {24'h0, mem[8]}, {24'h0, v0});
    @(negedge clk);
    rst = 1'b0;
    run_xfer("post_reset_fill", 1'b1, 8'h00, 8'h40, 8'd3, 8'h77, -1, 1'b0, od, ow);
    chk("post_reset_fill done cycle", 32'(od), 32'd4);

    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    load_mem();
    for (int r = 0; r < 30; r++) begin
      logic [7:0] rl;
      int         aa;
      rl = 8'($urandom_range(0, 10));
      aa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2 * int'(rl))) : -1;
      run_xfer($sformatf("rand%0d", r), 1'($urandom), 8'($urandom), 8'($urandom), rl,
               8'($urandom), aa, 1'($urandom), od, ow);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
